// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner
//   Front end for the traffic_light controller. It synchronises and debounces the two raw
//   car sensors. It latches each sensor into a sticky per-direction request that stays set
//   until that direction is granted green. It also counts the whole seconds each request
//   has been waiting, for the HEX display.
//
// Ports
//   CLOCK_50  in   1  system clock, rising edge
//   RESET     in   1  synchronous active-high reset
//   SW        in   2  raw car sensors [0]=North [1]=East (asynchronous, bouncing)
//   GRANT     in   2  controller green indication [0]=N [1]=E
//   REQ       out  2  sticky car requests to the controller
//   DEB       out  2  debounced sensor levels
//   TICK      out  1  one-cycle pulse every CNT_MAX clocks
//   WAIT_N    out  7  saturating seconds the North request has been pending
//   WAIT_E    out  7  saturating seconds the East request has been pending
module car_sensor_conditioner #(
  parameter int unsigned CNT_MAX  = 50_000_000,
  parameter int unsigned DEB_MAX  = 1_000_000,
  parameter int unsigned WAIT_MAX = 99
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [1:0] SW,
  input  logic [1:0] GRANT,
  output logic [1:0] REQ,
  output logic [1:0] DEB,
  output logic       TICK,
  output logic [6:0] WAIT_N,
  output logic [6:0] WAIT_E
);

  localparam int unsigned DCW = (DEB_MAX > 1) ? $clog2(DEB_MAX) : 1;
  localparam int unsigned PCW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned WW  = 7;

  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_MAX - 1);
  localparam logic [PCW-1:0] CNT_LAST = PCW'(CNT_MAX - 1);
  localparam logic [WW-1:0]  WAIT_SAT = WW'(WAIT_MAX);

  logic [1:0]     s1_q, s1_d;
  logic [1:0]     s2_q, s2_d;
  logic [1:0]     deb_q, deb_d;
  logic [DCW-1:0] dcnt_q [2];
  logic [DCW-1:0] dcnt_d [2];
  logic [1:0]     req_q, req_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic           tick_q, tick_d;
  logic [WW-1:0]  wait_n_q, wait_n_d;
  logic [WW-1:0]  wait_e_q, wait_e_d;

  // Wait counter for one direction. The count clears on the same edge as the request
  // (grant) and only advances while the request is already registered. This keeps the
  // first increment 1..CNT_MAX clocks after REQ rises.
  function automatic logic [WW-1:0] next_wait(input logic [WW-1:0] cur,
                                               input logic          req,
                                               input logic          grant,
                                               input logic          tick);
    logic [WW-1:0] nxt;
    nxt = cur;
    if (!req || grant) begin
      nxt = '0;
    end else if (tick && (cur < WAIT_SAT)) begin
      nxt = cur + WW'(1);
    end
    return nxt;
  endfunction

  // Synchroniser, debouncer, request latch, prescaler and wait counters
  always_comb begin
    s1_d     = SW;
    s2_d     = s1_q;
    deb_d    = deb_q;
    dcnt_d   = dcnt_q;
    req_d    = req_q;
    pcnt_d   = pcnt_q;
    tick_d   = 1'b0;
    wait_n_d = wait_n_q;
    wait_e_d = wait_e_q;

    // A level is accepted only after DEB_MAX consecutive disagreeing samples
    for (int b = 0; b < 2; b++) begin
      if (s2_q[b] == deb_q[b]) begin
        dcnt_d[b] = '0;
      end else if (dcnt_q[b] == DEB_LAST) begin
        deb_d[b]  = s2_q[b];
        dcnt_d[b] = '0;
      end else begin
        dcnt_d[b] = dcnt_q[b] + DCW'(1);
      end
    end

    // Grant clears the request and takes priority over a present car
    for (int b = 0; b < 2; b++) begin
      if (GRANT[b]) begin
        req_d[b] = 1'b0;
      end else if (deb_q[b]) begin
        req_d[b] = 1'b1;
      end
    end

    // Free-running seconds prescaler
    if (pcnt_q == CNT_LAST) begin
      pcnt_d = '0;
      tick_d = 1'b1;
    end else begin
      pcnt_d = pcnt_q + PCW'(1);
    end

    wait_n_d = next_wait(wait_n_q, req_q[0], GRANT[0], tick_q);
    wait_e_d = next_wait(wait_e_q, req_q[1], GRANT[1], tick_q);
  end

  // State registers
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      s1_q      <= '0;
      s2_q      <= '0;
      deb_q     <= '0;
      dcnt_q[0] <= '0;
      dcnt_q[1] <= '0;
      req_q     <= '0;
      pcnt_q    <= '0;
      tick_q    <= 1'b0;
      wait_n_q  <= '0;
      wait_e_q  <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      deb_q     <= deb_d;
      dcnt_q[0] <= dcnt_d[0];
      dcnt_q[1] <= dcnt_d[1];
      req_q     <= req_d;
      pcnt_q    <= pcnt_d;
      tick_q    <= tick_d;
      wait_n_q  <= wait_n_d;
      wait_e_q  <= wait_e_d;
    end
  end

  assign REQ    = req_q;
  assign DEB    = deb_q;
  assign TICK   = tick_q;
  assign WAIT_N = wait_n_q;
  assign WAIT_E = wait_e_q;

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Bench for car_sensor_conditioner: directed scenarios plus randomized sensor/grant
// traffic, compared every cycle against a behavioural model.
module tb_car_sensor_conditioner;

  localparam int CNT_MAX  = 5;
  localparam int DEB_MAX  = 4;
  localparam int WAIT_MAX = 99;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw;
  logic [1:0] grant;
  logic [1:0] req;
  logic [1:0] deb;
  logic       tick;
  logic [6:0] wait_n;
  logic [6:0] wait_e;

  always #5 clk = ~clk;

  car_sensor_conditioner #(
    .CNT_MAX (CNT_MAX),
    .DEB_MAX (DEB_MAX),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .SW      (sw),
    .GRANT   (grant),
    .REQ     (req),
    .DEB     (deb),
    .TICK    (tick),
    .WAIT_N  (wait_n),
    .WAIT_E  (wait_e)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sensor levels seen by the debouncer trail SW by two edges; a level is accepted after
  // DEB_MAX consecutive disagreeing observations; ticks fall on every CNT_MAX-th edge
  // since reset.
  bit         m_valid = 1'b0;
  logic [1:0] m_deb, m_req, n_deb, n_req, seen;
  bit         m_tick;
  int         m_wait [2];
  int         n_wait [2];
  int         m_edges;
  int         run [2];
  logic [1:0] sw_hist [$];

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_deb   = 2'b00;
      m_req   = 2'b00;
      m_tick  = 1'b0;
      m_wait  = '{0, 0};
      m_edges = 0;
      run     = '{0, 0};
      sw_hist = '{2'b00, 2'b00};
    end else if (m_valid) begin
      seen  = sw_hist[1];
      n_deb = m_deb;
      for (int b = 0; b < 2; b++) begin
        n_req[b] = grant[b] ? 1'b0 : (m_deb[b] ? 1'b1 : m_req[b]);
        if (!m_req[b] || grant[b])
          n_wait[b] = 0;
        else if (m_tick && m_wait[b] < WAIT_MAX)
          n_wait[b] = m_wait[b] + 1;
        else
          n_wait[b] = m_wait[b];
        if (seen[b] == m_deb[b]) begin
          run[b] = 0;
        end else begin
          run[b]++;
          if (run[b] == DEB_MAX) begin
            n_deb[b] = seen[b];
            run[b]   = 0;
          end
        end
      end
      m_deb   = n_deb;
      m_req   = n_req;
      m_wait  = n_wait;
      m_edges++;
      m_tick  = (m_edges % CNT_MAX) == 0;
      sw_hist.push_front(sw);
      void'(sw_hist.pop_back());
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("req_model",    int'(req),    int'(m_req));
      check("deb_model",    int'(deb),    int'(m_deb));
      check("tick_model",   int'(tick),   int'(m_tick));
      check("wait_n_model", int'(wait_n), m_wait[0]);
      check("wait_e_model", int'(wait_e), m_wait[1]);
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int t;
    int guard;
    int hold;

    rst   = 1'b1;
    sw    = 2'b11;
    grant = 2'b00;

    // 1. reset with sensors active, then prescaler period
    repeat (3) @(negedge clk);
    check("rst_req",    int'(req),    0);
    check("rst_deb",    int'(deb),    0);
    check("rst_tick",   int'(tick),   0);
    check("rst_wait_n", int'(wait_n), 0);
    check("rst_wait_e", int'(wait_e), 0);
    rst = 1'b0;
    sw  = 2'b00;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("tick_period", int'(tick), (i % 5 == 0) ? 1 : 0);
    end

    // 2. bounces shorter than the debounce window never pass
    for (int r = 0; r < 4; r++) begin
      sw[1] = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check("bounce_deb1", int'(deb[1]), 0);
        check("bounce_req1", int'(req[1]), 0);
      end
      sw[1] = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("bounce_deb1", int'(deb[1]), 0);
        check("bounce_req1", int'(req[1]), 0);
      end
    end
    repeat (6) @(negedge clk);

    // 3. exact latency SW -> DEB (6 edges) -> REQ (7 edges)
    sw[1] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      check("lat_deb1", int'(deb[1]), (e >= 6) ? 1 : 0);
      check("lat_req1", int'(req[1]), (e >= 7) ? 1 : 0);
    end

    // 4. request is sticky after the car leaves, cleared by a grant pulse
    sw[1] = 1'b0;
    repeat (50) begin
      @(negedge clk);
      check("sticky_req1", int'(req[1]), 1);
    end
    grant[1] = 1'b1;
    @(negedge clk);
    grant[1] = 1'b0;
    check("grant_req1",   int'(req[1]), 0);
    check("grant_wait_e", int'(wait_e), 0);

    // 5. wait counter counts ticks and saturates
    sw[0] = 1'b1;
    guard = 0;
    while (req[0] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req0_rise", int'(req[0]), 1);
    check("wait_n_start", int'(wait_n), 0);
    t = 0;
    guard = 0;
    while (t < 12 && guard < 200) begin
      if (tick) t++;
      @(negedge clk);
      guard++;
    end
    check("wait_n_12", int'(wait_n), 12);
    t = 0;
    guard = 0;
    while (t < 600 && guard < 5000) begin
      if (tick) t++;
      @(negedge clk);
      guard++;
      if (t > 100) check("wait_n_sat", int'(wait_n), 99);
    end
    check("wait_n_99", int'(wait_n), 99);

    // 6. grant while car present, re-assert after grant falls
    grant[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("grant_req0", int'(req[0]), 0);
      check("grant_wait_n", int'(wait_n), 0);
    end
    grant[0] = 1'b0;
    @(negedge clk);
    check("reassert_req0", int'(req[0]), 1);

    // Reset mid-wait discards the count
    guard = 0;
    while (wait_n != 7'd40 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("wait_n_40", int'(wait_n), 40);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_wait_n", int'(wait_n), 0);
    check("midrst_req",    int'(req),    0);
    rst = 1'b0;
    sw  = 2'b00;

    // Randomized traffic with occasional grants and resets
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        sw   = 2'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      grant = ($urandom_range(0, 11) == 0) ? 2'($urandom) : 2'b00;
      rst   = ($urandom_range(0, 699) == 0);
      @(negedge clk);
    end
    rst   = 1'b0;
    grant = 2'b00;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
